// File: rtl/polygon_loader.sv
// polygon_loader: serial vertex loader with shadow and active banks.
// Define POLYGON_LOADER_BBOX_EN to add a committed bounding box output.
module polygon_loader #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         vertex_valid_in,
  output logic                         vertex_ready_out,
  input  logic signed [WORLD_BITS-1:0] vertex_x_in,
  input  logic signed [WORLD_BITS-1:0] vertex_y_in,
  input  logic                         vertex_last_in,
  input  logic                         new_frame_in,
  output logic signed [WORLD_BITS-1:0] poly_xs_out [MAX_NUM_VERTICES],
  output logic signed [WORLD_BITS-1:0] poly_ys_out [MAX_NUM_VERTICES],
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0] num_points_out,
  output logic                         poly_valid_out,
`ifdef POLYGON_LOADER_BBOX_EN
  output logic signed [WORLD_BITS-1:0] bbox_min_x_out,
  output logic signed [WORLD_BITS-1:0] bbox_max_x_out,
  output logic signed [WORLD_BITS-1:0] bbox_min_y_out,
  output logic signed [WORLD_BITS-1:0] bbox_max_y_out,
`endif
  output logic                         overflow_err_out,
  output logic                         degenerate_err_out
);

  localparam int CW = $clog2(MAX_NUM_VERTICES + 1);
  localparam int IW = (MAX_NUM_VERTICES > 1) ?
                      $clog2(MAX_NUM_VERTICES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DISCARD,
    PENDING
  } state_t;

  state_t          state_q;
  state_t          state_nx;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_nx;
  logic            ready_q;
  logic            accept;
  logic            wr_en;
  logic            swap;
  logic            ovf_nx;
  logic            deg_nx;
  logic [IW-1:0]   wr_idx;

  logic signed [WORLD_BITS-1:0] sh_x [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] sh_y [MAX_NUM_VERTICES];

  assign accept           = vertex_valid_in && ready_q;
  assign vertex_ready_out = ready_q;
  assign wr_idx = (state_q == IDLE) ? '0 : count_q[IW-1:0];

  // Next state, shadow count, write enable, swap and error decisions.
  always_comb begin
    state_nx = state_q;
    count_nx = count_q;
    wr_en    = 1'b0;
    swap     = 1'b0;
    ovf_nx   = 1'b0;
    deg_nx   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (vertex_last_in) begin
            deg_nx   = 1'b1;
            count_nx = '0;
          end else begin
            count_nx = CW'(1);
            state_nx = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (count_q == CW'(MAX_NUM_VERTICES)) begin
            if (vertex_last_in) begin
              ovf_nx   = 1'b1;
              count_nx = '0;
              state_nx = IDLE;
            end else begin
              state_nx = DISCARD;
            end
          end else begin
            wr_en    = 1'b1;
            count_nx = count_q + CW'(1);
            if (vertex_last_in) begin
              if (count_nx >= CW'(3)) begin
                state_nx = PENDING;
              end else begin
                deg_nx   = 1'b1;
                count_nx = '0;
                state_nx = IDLE;
              end
            end
          end
        end
      end
      DISCARD: begin
        if (accept && vertex_last_in) begin
          ovf_nx   = 1'b1;
          count_nx = '0;
          state_nx = IDLE;
        end
      end
      PENDING: begin
        if (new_frame_in) begin
          swap     = 1'b1;
          count_nx = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        count_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // State register; ready follows the next state so it never sees valid.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q            <= IDLE;
      count_q            <= '0;
      ready_q            <= 1'b1;
      overflow_err_out   <= 1'b0;
      degenerate_err_out <= 1'b0;
    end else begin
      state_q            <= state_nx;
      count_q            <= count_nx;
      ready_q            <= (state_nx != PENDING);
      overflow_err_out   <= ovf_nx;
      degenerate_err_out <= deg_nx;
    end
  end

  // Shadow bank capture of accepted beats.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
      end
    end else if (wr_en) begin
      sh_x[wr_idx] <= vertex_x_in;
      sh_y[wr_idx] <= vertex_y_in;
    end
  end

  // Active bank: loaded from the shadow only at a frame-boundary swap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        poly_xs_out[i] <= '0;
        poly_ys_out[i] <= '0;
      end
      num_points_out <= '0;
      poly_valid_out <= 1'b0;
    end else if (swap) begin
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        poly_xs_out[i] <= sh_x[i];
        poly_ys_out[i] <= sh_y[i];
      end
      num_points_out <= count_q;
      poly_valid_out <= 1'b1;
    end
  end

`ifdef POLYGON_LOADER_BBOX_EN
  logic                         seed;
  logic signed [WORLD_BITS-1:0] bx_min_x;
  logic signed [WORLD_BITS-1:0] bx_max_x;
  logic signed [WORLD_BITS-1:0] bx_min_y;
  logic signed [WORLD_BITS-1:0] bx_max_y;

  assign seed = wr_en && (state_q == IDLE);

  // Running box over stored beats; the first beat of a polygon seeds it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bx_min_x <= '0;
      bx_max_x <= '0;
      bx_min_y <= '0;
      bx_max_y <= '0;
    end else if (seed) begin
      bx_min_x <= vertex_x_in;
      bx_max_x <= vertex_x_in;
      bx_min_y <= vertex_y_in;
      bx_max_y <= vertex_y_in;
    end else if (wr_en) begin
      if (vertex_x_in < bx_min_x) bx_min_x <= vertex_x_in;
      if (vertex_x_in > bx_max_x) bx_max_x <= vertex_x_in;
      if (vertex_y_in < bx_min_y) bx_min_y <= vertex_y_in;
      if (vertex_y_in > bx_max_y) bx_max_y <= vertex_y_in;
    end
  end

  // Committed box moves with the arrays at swap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bbox_min_x_out <= '0;
      bbox_max_x_out <= '0;
      bbox_min_y_out <= '0;
      bbox_max_y_out <= '0;
    end else if (swap) begin
      bbox_min_x_out <= bx_min_x;
      bbox_max_x_out <= bx_max_x;
      bbox_min_y_out <= bx_min_y;
      bbox_max_y_out <= bx_max_y;
    end
  end
`endif

endmodule

// File: tb/tb_polygon_loader.sv
// tb_polygon_loader: directed bench with a committed-polygon scoreboard.
// Beats feed a shadow model; frame strobes pop the expected active bank.
module tb_polygon_loader;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int CW = $clog2(N + 1);

  logic                clk_in = 1'b0;
  logic                rst_n_in = 1'b0;
  logic                vertex_valid_in = 1'b0;
  logic                vertex_ready_out;
  logic signed [W-1:0] vertex_x_in = '0;
  logic signed [W-1:0] vertex_y_in = '0;
  logic                vertex_last_in = 1'b0;
  logic                new_frame_in = 1'b0;
  logic signed [W-1:0] poly_xs_out [N];
  logic signed [W-1:0] poly_ys_out [N];
  logic [CW-1:0]       num_points_out;
  logic                poly_valid_out;
  logic                overflow_err_out;
  logic                degenerate_err_out;
`ifdef POLYGON_LOADER_BBOX_EN
  logic signed [W-1:0] bbox_min_x_out;
  logic signed [W-1:0] bbox_max_x_out;
  logic signed [W-1:0] bbox_min_y_out;
  logic signed [W-1:0] bbox_max_y_out;
`endif

  polygon_loader #(
    .WORLD_BITS(W),
    .MAX_NUM_VERTICES(N)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .vertex_valid_in(vertex_valid_in),
    .vertex_ready_out(vertex_ready_out),
    .vertex_x_in(vertex_x_in),
    .vertex_y_in(vertex_y_in),
    .vertex_last_in(vertex_last_in),
    .new_frame_in(new_frame_in),
    .poly_xs_out(poly_xs_out),
    .poly_ys_out(poly_ys_out),
    .num_points_out(num_points_out),
    .poly_valid_out(poly_valid_out),
`ifdef POLYGON_LOADER_BBOX_EN
    .bbox_min_x_out(bbox_min_x_out),
    .bbox_max_x_out(bbox_max_x_out),
    .bbox_min_y_out(bbox_min_y_out),
    .bbox_max_y_out(bbox_max_y_out),
`endif
    .overflow_err_out(overflow_err_out),
    .degenerate_err_out(degenerate_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int                  n;
    logic signed [W-1:0] xs [N];
    logic signed [W-1:0] ys [N];
  } poly_t;

  poly_t sb_q[$];
  poly_t cur;
  poly_t act;
  bit    act_valid;
  int    errors = 0;
  int    checks = 0;

  function automatic poly_t empty_poly();
    poly_t p;
    p.n = 0;
    for (int i = 0; i < N; i++) begin
      p.xs[i] = '0;
      p.ys[i] = '0;
    end
    return p;
  endfunction

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Shadow model: commit only polygons of 3..N vertices.
  task automatic model_add(input int x, input int y, input bit last);
    if (cur.n < N) begin
      cur.xs[cur.n] = x;
      cur.ys[cur.n] = y;
    end
    cur.n++;
    if (last) begin
      if (cur.n >= 3 && cur.n <= N) sb_q.push_back(cur);
      cur = empty_poly();
    end
  endtask

  // Called just after a negedge; returns just after the next accepting one.
  task automatic beat(input int x, input int y, input bit last);
    int g;
    g = 0;
    vertex_valid_in = 1'b1;
    vertex_x_in     = x;
    vertex_y_in     = y;
    vertex_last_in  = last;
    while (vertex_ready_out !== 1'b1 && g < 50) begin
      @(negedge clk_in);
      g++;
    end
    chk("ready_wait", vertex_ready_out, 1);
    @(negedge clk_in);
    vertex_valid_in = 1'b0;
    vertex_last_in  = 1'b0;
    model_add(x, y, last);
  endtask

  task automatic check_active(input string tag);
    logic signed [W-1:0] mnx, mxx, mny, mxy;
    chk({tag, ".n"}, num_points_out, act.n);
    chk({tag, ".valid"}, poly_valid_out, act_valid);
    for (int i = 0; i < act.n; i++) begin
      chk({tag, ".x"}, poly_xs_out[i], act.xs[i]);
      chk({tag, ".y"}, poly_ys_out[i], act.ys[i]);
    end
    mnx = act.xs[0]; mxx = act.xs[0];
    mny = act.ys[0]; mxy = act.ys[0];
    for (int i = 1; i < act.n; i++) begin
      if (act.xs[i] < mnx) mnx = act.xs[i];
      if (act.xs[i] > mxx) mxx = act.xs[i];
      if (act.ys[i] < mny) mny = act.ys[i];
      if (act.ys[i] > mxy) mxy = act.ys[i];
    end
`ifdef POLYGON_LOADER_BBOX_EN
    chk({tag, ".bminx"}, bbox_min_x_out, mnx);
    chk({tag, ".bmaxx"}, bbox_max_x_out, mxx);
    chk({tag, ".bminy"}, bbox_min_y_out, mny);
    chk({tag, ".bmaxy"}, bbox_max_y_out, mxy);
`endif
  endtask

  task automatic pop_expected();
    if (sb_q.size() > 0) begin
      act       = sb_q.pop_front();
      act_valid = 1'b1;
    end
  endtask

  task automatic frame(input string tag);
    new_frame_in = 1'b1;
    @(negedge clk_in);
    new_frame_in = 1'b0;
    pop_expected();
    check_active(tag);
    chk({tag, ".ready"}, vertex_ready_out, 1);
  endtask

  task automatic triangle();
    beat(0, 0, 1'b0);
    beat(100, 0, 1'b0);
    beat(0, 100, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    cur       = empty_poly();
    act       = empty_poly();
    act_valid = 1'b0;

    // Reset state
    #1;
    chk("rst.n", num_points_out, 0);
    chk("rst.valid", poly_valid_out, 0);
    chk("rst.ovf", overflow_err_out, 0);
    chk("rst.deg", degenerate_err_out, 0);
    chk("rst.x0", poly_xs_out[0], 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("rst.ready", vertex_ready_out, 1);

    // Triangle, then backpressure while pending
    triangle();
    chk("tri.ready", vertex_ready_out, 0);
    chk("tri.deg", degenerate_err_out, 0);
    chk("tri.ovf", overflow_err_out, 0);
    vertex_valid_in = 1'b1;
    vertex_x_in     = 7;
    vertex_y_in     = 8;
    vertex_last_in  = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      chk("bp.ready", vertex_ready_out, 0);
      chk("bp.valid", poly_valid_out, 0);
    end
    new_frame_in = 1'b1;
    @(negedge clk_in);
    new_frame_in = 1'b0;
    pop_expected();
    check_active("tri");
    chk("tri.ready_after", vertex_ready_out, 1);
    @(negedge clk_in);
    vertex_valid_in = 1'b0;
    model_add(7, 8, 1'b0);
    beat(-9, 10, 1'b0);
    beat(11, -12, 1'b1);
    frame("held");

    // Full-capacity polygon
    for (int i = 0; i < N; i++) begin
      beat(i * 3 - 40, 1000 - i * 7, i == N - 1);
    end
    chk("full.ready", vertex_ready_out, 0);
    frame("full");

    // Overflow: 35 beats leave the committed triangle intact
    triangle();
    frame("tri2");
    for (int i = 0; i < 35; i++) begin
      beat(i + 500, -i, i == 34);
      if (i == 33) chk("ovf.early", overflow_err_out, 0);
    end
    chk("ovf.pulse", overflow_err_out, 1);
    @(negedge clk_in);
    chk("ovf.width", overflow_err_out, 0);
    frame("ovf");

    // Degenerate: two vertices
    beat(5, 5, 1'b0);
    beat(6, 6, 1'b1);
    chk("deg.pulse", degenerate_err_out, 1);
    chk("deg.ovf", overflow_err_out, 0);
    chk("deg.ready", vertex_ready_out, 1);
    @(negedge clk_in);
    chk("deg.width", degenerate_err_out, 0);
    frame("deg");

    // Strobe coinciding with the last beat does not swap
    beat(-3, -3, 1'b0);
    beat(30, -3, 1'b0);
    new_frame_in = 1'b1;
    beat(-3, 40, 1'b1);
    new_frame_in = 1'b0;
    check_active("sim.noswap");
    chk("sim.ready", vertex_ready_out, 0);
    frame("sim");

    // Reset dropped mid-FILL between clock edges
    beat(1, 1, 1'b0);
    beat(2, 2, 1'b0);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("mrst.valid", poly_valid_out, 0);
    chk("mrst.n", num_points_out, 0);
    sb_q.delete();
    cur       = empty_poly();
    act       = empty_poly();
    act_valid = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("mrst.ready", vertex_ready_out, 1);
    beat(-50, 20, 1'b0);
    beat(60, 25, 1'b0);
    beat(10, -70, 1'b1);
    frame("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
